// File: rtl/block_f_pkg.sv
// rtl/block_f_pkg.sv - shared constants and sizing helper for the block_f datapath
// Contents: BF_IN_W (adder input width), BF_OUT_W (signed adder output width),
//           min_acc_w(len) (smallest accumulator width that cannot overflow).
package block_f_pkg;

  localparam int BF_IN_W  = 11;
  localparam int BF_OUT_W = 5;

  // Smallest w with 2^(w-1) > BF_IN_W*len, i.e. a signed w-bit register holds
  // the full +/- BF_IN_W*len frame range.
  function automatic int min_acc_w(input int len);
    for (int w = 2; w < 32; w++) begin
      if ((64'd1 << (w - 1)) > 64'(BF_IN_W * len)) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/block_f.sv
// rtl/block_f.sv - 11-input +/-1 adder: each input bit counts +1 when set, -1 when clear
// Ports: data_i [BF_IN_W] input vector; sum_o [BF_OUT_W] signed 2*popcount-11.
module block_f
  import block_f_pkg::*;
(
  input  logic [BF_IN_W-1:0]         data_i,
  output logic signed [BF_OUT_W-1:0] sum_o
);

  logic [3:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < BF_IN_W; i++) begin
      ones = ones + {3'b000, data_i[i]};
    end
  end

  // 2*ones ranges 0..22 and the result -11..+11, both of which fit in 5 bits.
  assign sum_o = signed'({ones, 1'b0} - 5'd11);

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with hold/advance control
// Ports: clk_i, rst_i (async, active high), valid_i[1:0] requests,
//        advance_i (pointer may move this cycle), grant_o[1:0] one-hot grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Priority passes to whichever requester was not granted.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/block_f_rr_accum.sv
// rtl/block_f_rr_accum.sv - round-robin frame accumulator sharing one block_f adder
// Ports: clk, rst (async, active high); req0/req1 valid/data/ready word inputs;
//        res_valid/res_id/res_sum result output with res_ready backpressure.
module block_f_rr_accum
  import block_f_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int ACC_W = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [BF_IN_W-1:0]      req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [BF_IN_W-1:0]      req1_data,
  output logic                    req1_ready,
  output logic                    res_valid,
  output logic                    res_id,
  output logic signed [ACC_W-1:0] res_sum,
  input  logic                    res_ready
);

  localparam int CNT_W = $clog2(LEN);

  logic                    stall;
  logic [1:0]              grant;
  logic                    accept;

  logic                    s1_vld_q, s1_vld_d;
  logic                    s1_id_q, s1_id_d;
  logic [BF_IN_W-1:0]      s1_data_q, s1_data_d;

  logic signed [ACC_W-1:0] acc_q [2];
  logic signed [ACC_W-1:0] acc_d [2];
  logic [CNT_W-1:0]        cnt_q [2];
  logic [CNT_W-1:0]        cnt_d [2];

  logic                    res_valid_q, res_valid_d;
  logic                    res_id_q, res_id_d;
  logic signed [ACC_W-1:0] res_sum_q, res_sum_d;

  logic signed [BF_OUT_W-1:0] bf_sum;
  logic signed [ACC_W-1:0]    word_val;

  // A held result freezes the whole pipeline, arbiter pointer included.
  assign stall = res_valid_q & ~res_ready;

  rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .valid_i   ({req1_valid, req0_valid}),
    .advance_i (~stall),
    .grant_o   (grant)
  );

  assign req0_ready = ~stall & grant[0];
  assign req1_ready = ~stall & grant[1];
  assign accept     = req0_ready | req1_ready;

  block_f u_block_f (
    .data_i (s1_data_q),
    .sum_o  (bf_sum)
  );

  assign word_val = {{(ACC_W - BF_OUT_W){bf_sum[BF_OUT_W-1]}}, bf_sum};

  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_id_d     = s1_id_q;
    s1_data_d   = s1_data_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;

    if (!stall) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_id_d   = req1_ready;
        s1_data_d = req1_ready ? req1_data : req0_data;
      end

      // Not stalled means any held result is consumed this edge, so res_valid
      // only stays high when a new frame completes (back-to-back results).
      res_valid_d = 1'b0;
      if (s1_vld_q) begin
        if (cnt_q[s1_id_q] == CNT_W'(LEN - 1)) begin
          res_valid_d     = 1'b1;
          res_id_d        = s1_id_q;
          res_sum_d       = acc_q[s1_id_q] + word_val;
          acc_d[s1_id_q]  = '0;
          cnt_d[s1_id_q]  = '0;
        end else begin
          acc_d[s1_id_q]  = acc_q[s1_id_q] + word_val;
          cnt_d[s1_id_q]  = cnt_q[s1_id_q] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_id_q     <= 1'b0;
      s1_data_q   <= '0;
      acc_q[0]    <= '0;
      acc_q[1]    <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_sum_q   <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      s1_data_q   <= s1_data_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;

endmodule

// File: tb/tb_block_f_rr_accum.sv
// tb/tb_block_f_rr_accum.sv - self-checking bench for block_f_rr_accum with LEN=4
module tb_block_f_rr_accum;
  import block_f_pkg::*;

  localparam int LEN   = 4;
  localparam int ACC_W = 9;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req0_valid = 1'b0;
  logic [10:0]             req0_data = '0;
  logic                    req0_ready;
  logic                    req1_valid = 1'b0;
  logic [10:0]             req1_data = '0;
  logic                    req1_ready;
  logic                    res_valid;
  logic                    res_id;
  logic signed [ACC_W-1:0] res_sum;
  logic                    res_ready = 1'b1;

  always #5 clk = ~clk;

  block_f_rr_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_ready  (res_ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: per-requester running sums/word counts, a one-word
  // pending slot and the result register, all in plain integers.
  int m_ptr, m_s1_v, m_s1_id, m_s1_val, m_res_v, m_res_id, m_res_sum;
  int m_sum [2];
  int m_cnt [2];
  int acc_ids [$];

  function automatic int wval(input logic [10:0] d);
    return 2 * $countones(d) - 11;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_s1_v = 0; m_s1_id = 0; m_s1_val = 0;
    m_res_v = 0; m_res_id = 0; m_res_sum = 0;
    m_sum[0] = 0; m_sum[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // One clock cycle: drive, check combinational and registered outputs,
  // advance the model at the edge, return at the following negedge.
  task automatic step(input bit v0, input logic [10:0] d0,
                      input bit v1, input logic [10:0] d1, input bit rr);
    int  g;
    bit  stall;
    int  nv;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    res_ready  = rr;
    #1;
    stall = (m_res_v != 0) && !rr;
    g = -1;
    if (!stall) begin
      if (v0 && v1) g = m_ptr;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("req0_ready", int'(req0_ready), int'(g == 0));
    chk("req1_ready", int'(req1_ready), int'(g == 1));
    chk("res_valid", int'(res_valid), m_res_v);
    if (m_res_v != 0) begin
      chk("res_id", int'(res_id), m_res_id);
      chk("res_sum", int'($signed(res_sum)), m_res_sum);
    end
    if (req0_ready) acc_ids.push_back(0);
    else if (req1_ready) acc_ids.push_back(1);
    @(posedge clk);
    if (!stall) begin
      nv = 0;
      if (m_s1_v != 0) begin
        m_sum[m_s1_id] += m_s1_val;
        m_cnt[m_s1_id]++;
        if (m_cnt[m_s1_id] == LEN) begin
          nv        = 1;
          m_res_id  = m_s1_id;
          m_res_sum = m_sum[m_s1_id];
          m_sum[m_s1_id] = 0;
          m_cnt[m_s1_id] = 0;
        end
      end
      m_res_v = nv;
      m_s1_v  = (g >= 0);
      if (g >= 0) begin
        m_s1_id  = g;
        m_s1_val = wval(g == 1 ? d1 : d0);
        m_ptr    = 1 - g;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
    #1;
    model_reset();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_sum", int'($signed(res_sum)), 0);
    chk("rst_req0_ready", int'(req0_ready), 1);
    chk("rst_req1_ready", int'(req1_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
  endtask

  task automatic chk_res(input string tag, input int id, input int sum);
    chk({tag, "_valid"}, int'(res_valid), 1);
    chk({tag, "_id"}, int'(res_id), id);
    chk({tag, "_sum"}, int'($signed(res_sum)), sum);
  endtask

  logic [10:0] w_mix [4];
  logic [10:0] rd0, rd1;

  initial begin
    model_reset();
    chk("min_acc_w_len4", min_acc_w(4), 7);
    chk("min_acc_w_len16", min_acc_w(16), 9);
    @(negedge clk);
    do_reset();

    // Single requester, all ones: +44, result one edge after the last word.
    for (int i = 0; i < 4; i++) step(1, 11'h7FF, 0, 11'h000, 1);
    chk("t1_latency_valid", int'(res_valid), 0);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t1", 0, 44);

    // Requester 1, all zeros: -44.
    for (int i = 0; i < 4; i++) step(0, 11'h000, 1, 11'h000, 1);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t2", 1, -44);

    // Both continuously valid: alternating grants, back-to-back results.
    acc_ids.delete();
    for (int i = 0; i < 8; i++) step(1, 11'h7FF, 1, 11'h001, 1);
    chk("t3_grant_count", acc_ids.size(), 8);
    for (int i = 0; i < acc_ids.size(); i++) chk("t3_grant_order", acc_ids[i], i % 2);
    chk_res("t3_first", 0, 44);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t3_second", 1, -36);
    step(0, 11'h000, 0, 11'h000, 1);

    // Backpressure: hold the first result, then release for one cycle.
    for (int i = 0; i < 8; i++) step(1, 11'h7FF, 1, 11'h001, 1);
    chk_res("t4_first", 0, 44);
    for (int i = 0; i < 3; i++) step(1, 11'h7FF, 1, 11'h001, 0);
    chk_res("t4_held", 0, 44);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t4_second", 1, -36);
    step(0, 11'h000, 0, 11'h000, 1);

    // Reset mid-frame discards the partial sum.
    step(1, 11'h7FF, 0, 11'h000, 1);
    step(1, 11'h7FF, 0, 11'h000, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 11'h03F, 0, 11'h000, 1);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t5", 0, 4);
    step(0, 11'h000, 0, 11'h000, 1);

    // Mixed words summing to zero.
    w_mix[0] = 11'h000; w_mix[1] = 11'h7FF; w_mix[2] = 11'h01F; w_mix[3] = 11'h03F;
    for (int i = 0; i < 4; i++) step(1, w_mix[i], 0, 11'h000, 1);
    step(0, 11'h000, 0, 11'h000, 1);
    chk_res("t6", 0, 0);

    // Randomized traffic with random backpressure against the model.
    for (int i = 0; i < 600; i++) begin
      rd0 = 11'($urandom);
      rd1 = 11'($urandom);
      step($urandom_range(0, 3) != 0, rd0, $urandom_range(0, 3) != 0, rd1,
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 11'h000, 0, 11'h000, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
